guess_sequencer: RTL

- Runs the answer phase of the braille trainer once the presentation controller finishes showing the 5 random characters.
- Sequences user entry slot by slot and arms the shared 2-second timer per slot.
- Compares each entered character against the held target and accumulates a score and per-slot hit flags for the display and LED logic.

---
 rtl/gs_pkg.sv | 15 +
 rtl/gs_scoreboard.sv | 51 +++++
 rtl/guess_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// Shared definitions for the braille trainer answer-phase sequencer.
package gs_pkg;
    localparam int GS_NCHAR = 5;   // characters per round
    localparam int GS_CW    = 4;   // character code width
    localparam int GS_SW    = 3;   // slot index width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } gs_state_t;
endpackage

// File: rtl/gs_scoreboard.sv
// Holds the latched round targets, compares a captured code against the
// current slot's target, and accumulates hits/score.
// The match output exists only when GUESS_RETRY_EN is defined.
module gs_scoreboard
    import gs_pkg::*;
#(
    parameter int NCHAR = GS_NCHAR,
    parameter int CW    = GS_CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               latch,
    input  logic               clear,
    input  logic               check,
    input  logic [GS_SW-1:0]   slot,
    input  logic [CW-1:0]      code,
    input  logic [NCHAR*CW-1:0] tgt,
    output logic [NCHAR-1:0]   hits,
    output logic [2:0]         score
`ifdef GUESS_RETRY_EN
    , output logic             match
`endif
);
    logic [NCHAR*CW-1:0] tgt_r;
    logic                hit;

    assign hit = (code == tgt_r[int'(slot)*CW +: CW]);
`ifdef GUESS_RETRY_EN
    assign match = hit;
`endif

    // Targets are captured once at round start; later tgt changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst)       tgt_r <= '0;
        else if (latch) tgt_r <= tgt;
    end

    // Each slot is checked at most once with a hit, so score cannot pass NCHAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hits  <= '0;
            score <= '0;
        end else if (clear) begin
            hits  <= '0;
            score <= '0;
        end else if (check && hit) begin
            hits[slot] <= 1'b1;
            score      <= score + 3'd1;
        end
    end
endmodule

// File: rtl/guess_sequencer.sv
// Answer-phase sequencer: walks the slots, arms the shared timer per slot,
// and scores each entry. Define GUESS_RETRY_EN to allow one retry per slot
// after a wrong entry (adds the retry output).
module guess_sequencer
    import gs_pkg::*;
#(
    parameter int NCHAR = GS_NCHAR,
    parameter int CW    = GS_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                allowgt,
    input  logic [NCHAR*CW-1:0] tgt,
    input  logic [CW-1:0]       guess,
    input  logic                enter,
    input  logic                timeout,
    output logic                reqtmr,
    output logic [GS_SW-1:0]    slot,
    output logic                busy,
    output logic [NCHAR-1:0]    hits,
    output logic [2:0]          score,
    output logic                done
`ifdef GUESS_RETRY_EN
    , output logic              retry
`endif
);
    gs_state_t       state, nstate;
    logic            allowgt_q, start_q;
    logic [CW-1:0]   cap;
    logic            abort, sb_latch, sb_check, cap_en, adv;
    logic            last;

    assign last  = (slot == GS_SW'(NCHAR - 1));
    assign abort = !allowgt && (state != IDLE) && (state != DONE);

`ifdef GUESS_RETRY_EN
    logic match, retry_set;
`endif

    gs_scoreboard #(.NCHAR(NCHAR), .CW(CW)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .latch (sb_latch),
        .clear (sb_latch),
        .check (sb_check),
        .slot  (slot),
        .code  (cap),
        .tgt   (tgt),
        .hits  (hits),
        .score (score)
`ifdef GUESS_RETRY_EN
        , .match (match)
`endif
    );

    // Registered rising edge of allowgt starts a round; a held level does not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            allowgt_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            allowgt_q <= allowgt;
            start_q   <= allowgt && !allowgt_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // Next-state and per-cycle strobes; an abort overrides everything.
    always_comb begin
        nstate   = state;
        reqtmr   = 1'b0;
        sb_latch = 1'b0;
        sb_check = 1'b0;
        cap_en   = 1'b0;
        adv      = 1'b0;
`ifdef GUESS_RETRY_EN
        retry_set = 1'b0;
`endif
        case (state)
            IDLE:  if (start_q) begin sb_latch = 1'b1; nstate = ARM; end
            ARM:   begin reqtmr = 1'b1; nstate = WAIT; end
            WAIT:  if (enter) begin cap_en = 1'b1; nstate = CHECK; end
                   else if (timeout) nstate = NEXT;
            CHECK: begin
                sb_check = 1'b1;
                nstate   = NEXT;
`ifdef GUESS_RETRY_EN
                if (!match && !retry) begin
                    retry_set = 1'b1;
                    nstate    = ARM;
                end
`endif
            end
            NEXT:  if (last) nstate = DONE;
                   else begin adv = 1'b1; nstate = ARM; end
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (abort) begin
            nstate   = IDLE;
            reqtmr   = 1'b0;
            sb_check = 1'b0;
            cap_en   = 1'b0;
            adv      = 1'b0;
`ifdef GUESS_RETRY_EN
            retry_set = 1'b0;
`endif
        end
    end

    // Slot counter, status flags and the captured entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            cap  <= '0;
        end else begin
            if (sb_latch) begin
                slot <= '0;
                busy <= 1'b1;
                done <= 1'b0;
            end
            if (cap_en) cap  <= guess;
            if (adv)    slot <= slot + 1'b1;
            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (abort) busy <= 1'b0;
        end
    end

`ifdef GUESS_RETRY_EN
    // One retry per slot; the flag clears whenever a new slot begins.
    always_ff @(posedge clk) begin
        if (!rst)                retry <= 1'b0;
        else if (sb_latch || adv) retry <= 1'b0;
        else if (retry_set)      retry <= 1'b1;
    end
`endif
endmodule
